// File: rtl/vx_issue_perf_ctrs.sv
// vx_issue_perf_ctrs: classifies issue-stage stall events and accumulates them into free-running perf counters
module vx_issue_perf_ctrs #(
   parameter int PERF_CTR_BITS = 44,
   parameter int NUM_THREADS   = 4,
   parameter int FPU_ENABLE    = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     perf_clear,
   input  logic                     perf_freeze,
   input  logic                     ibuf_in_valid,
   input  logic                     ibuf_in_ready,
   input  logic                     ibuf_out_valid,
   input  logic                     scb_ready,
   input  logic                     disp_valid,
   input  logic [2:0]               disp_ex_type,
   input  logic [NUM_THREADS-1:0]   disp_tmask,
   input  logic                     alu_ready,
   input  logic                     lsu_ready,
   input  logic                     csr_ready,
   input  logic                     fpu_ready,
   input  logic                     gpu_ready,
   output logic [PERF_CTR_BITS-1:0] ibf_stalls,
   output logic [PERF_CTR_BITS-1:0] scb_stalls,
   output logic [PERF_CTR_BITS-1:0] alu_stalls,
   output logic [PERF_CTR_BITS-1:0] lsu_stalls,
   output logic [PERF_CTR_BITS-1:0] csr_stalls,
   output logic [PERF_CTR_BITS-1:0] fpu_stalls,
   output logic [PERF_CTR_BITS-1:0] gpu_stalls,
   output logic [PERF_CTR_BITS-1:0] active_threads
);
   localparam int TW = $clog2(NUM_THREADS + 1);
   typedef struct packed {
      logic          ibf;
      logic          scb;
      logic          alu;
      logic          lsu;
      logic          csr;
      logic          fpu;
      logic          gpu;
      logic [TW-1:0] thr;
   } ev_t;
   ev_t ev_d, ev_q;
   logic unit_rdy;
   logic [TW-1:0] pop;
   logic [7:0][PERF_CTR_BITS-1:0] cnt_d, cnt_q;
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_THREADS; i++) pop = pop + TW'(disp_tmask[i]);
      unit_rdy = (disp_ex_type == 3'd0) ? alu_ready :
                 (disp_ex_type == 3'd1) ? lsu_ready :
                 (disp_ex_type == 3'd2) ? csr_ready :
                 (disp_ex_type == 3'd3) ? fpu_ready :
                 (disp_ex_type == 3'd4) ? gpu_ready : 1'b1;
      ev_d.ibf = ibuf_in_valid & ~ibuf_in_ready;
      ev_d.scb = ibuf_out_valid & ~scb_ready;
      ev_d.alu = disp_valid & (disp_ex_type == 3'd0) & ~alu_ready;
      ev_d.lsu = disp_valid & (disp_ex_type == 3'd1) & ~lsu_ready;
      ev_d.csr = disp_valid & (disp_ex_type == 3'd2) & ~csr_ready;
      ev_d.fpu = (FPU_ENABLE != 0) & disp_valid & (disp_ex_type == 3'd3) & ~fpu_ready;
      ev_d.gpu = disp_valid & (disp_ex_type == 3'd4) & ~gpu_ready;
      ev_d.thr = (disp_valid & unit_rdy) ? pop : '0;
      // frozen cycles load an empty event so nothing captured under freeze is ever counted
      ev_d = perf_freeze ? '0 : ev_d;
      cnt_d[0] = cnt_q[0] + PERF_CTR_BITS'(ev_q.ibf);
      cnt_d[1] = cnt_q[1] + PERF_CTR_BITS'(ev_q.scb);
      cnt_d[2] = cnt_q[2] + PERF_CTR_BITS'(ev_q.alu);
      cnt_d[3] = cnt_q[3] + PERF_CTR_BITS'(ev_q.lsu);
      cnt_d[4] = cnt_q[4] + PERF_CTR_BITS'(ev_q.csr);
      cnt_d[5] = cnt_q[5] + PERF_CTR_BITS'(ev_q.fpu);
      cnt_d[6] = cnt_q[6] + PERF_CTR_BITS'(ev_q.gpu);
      cnt_d[7] = cnt_q[7] + PERF_CTR_BITS'(ev_q.thr);
      cnt_d = perf_freeze ? cnt_q : cnt_d;
   end
   always_ff @(posedge clk) begin
      if (reset || perf_clear) begin
         ev_q  <= '0;
         cnt_q <= '0;
      end else begin
         ev_q  <= ev_d;
         cnt_q <= cnt_d;
      end
   end
   assign ibf_stalls     = cnt_q[0];
   assign scb_stalls     = cnt_q[1];
   assign alu_stalls     = cnt_q[2];
   assign lsu_stalls     = cnt_q[3];
   assign csr_stalls     = cnt_q[4];
   assign fpu_stalls     = cnt_q[5];
   assign gpu_stalls     = cnt_q[6];
   assign active_threads = cnt_q[7];
endmodule
